// File: rtl/cond_loop_pkg.sv
// cond_loop_pkg: shared FSM state type, data width and default loop bounds for cond_loop.
package cond_loop_pkg;
  localparam int DW = 32;
  localparam int DEF_LIMIT = 10;
  localparam int DEF_THRESH = 1000;
  typedef enum logic [2:0] {IDLE, INIT, COND, BODY, DONE} state_t;
endpackage

// File: rtl/cond_loop_core.sv
// cond_loop_core: loop FSM summing odd indices below LIMIT; COND_LOOP_BREAK_EN adds an early exit at THRESH.
module cond_loop_core import cond_loop_pkg::*; #(
  parameter int LIMIT = DEF_LIMIT,
  parameter int THRESH = DEF_THRESH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  output state_t        state,
  output logic [DW-1:0] result,
  output logic [DW-1:0] iter
);
  state_t state_n;
  logic [DW-1:0] sum, i, sum_n, i_n, acc;
  logic brk;
`ifdef COND_LOOP_BREAK_EN
  assign brk = acc >= DW'(THRESH);
`else
  logic unused_thresh;
  assign brk = 1'b0;
  assign unused_thresh = ^THRESH;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sum <= '0;
      i <= '0;
      result <= '0;
      iter <= '0;
    end else begin
      state <= state_n;
      sum <= sum_n;
      i <= i_n;
      if (state == DONE) begin
        result <= sum;
        iter <= i;
      end
    end
  // On a break i is left at the index whose term crossed the threshold
  always_comb begin
    acc = sum + (i[0] ? i : '0);
    state_n = state;
    sum_n = sum;
    i_n = i;
    case (state)
      IDLE: state_n = go ? INIT : IDLE;
      INIT: begin
        sum_n = '0;
        i_n = '0;
        state_n = COND;
      end
      COND: state_n = (i < DW'(LIMIT)) ? BODY : DONE;
      BODY: begin
        sum_n = acc;
        i_n = brk ? i : i + DW'(1);
        state_n = brk ? DONE : COND;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/cond_loop.sv
// cond_loop: run/start/join/yield handshakes around cond_loop_core (early break via COND_LOOP_BREAK_EN).
module cond_loop import cond_loop_pkg::*; #(
  parameter int LIMIT = DEF_LIMIT,
  parameter int THRESH = DEF_THRESH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_req,
  output logic          run_busy,
  input  logic          start_req,
  output logic          start_busy,
  input  logic          join_req,
  output logic          join_busy,
  input  logic          yield_req,
  output logic          yield_busy,
  output logic [DW-1:0] result_out,
  output logic [DW-1:0] iter_out
);
  state_t state;
  cond_loop_core #(.LIMIT(LIMIT), .THRESH(THRESH)) u_core (
    .clk(clk),
    .reset(reset),
    .go(run_req | start_req),
    .state(state),
    .result(result_out),
    .iter(iter_out)
  );
  assign run_busy = state != IDLE;
  // A pending join rides through DONE into the first idle cycle, then drops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      start_busy <= 1'b0;
      join_busy <= 1'b0;
      yield_busy <= 1'b0;
    end else begin
      start_busy <= start_req && !run_busy;
      join_busy <= run_busy ? (join_busy | join_req) : (join_req & ~join_busy);
      yield_busy <= yield_req;
    end
endmodule

// File: tb/tb_cond_loop.sv
// tb_cond_loop: vector table, corner sequences and randomized handshakes checked against a loop model.
module tb_cond_loop;
  localparam int LIMIT = 10;
`ifdef COND_LOOP_BREAK_EN
  localparam int TH = 10;
`else
  localparam int TH = 1000;
`endif
  logic clk = 0, reset = 1;
  logic run_req = 0, start_req = 0, join_req = 0, yield_req = 0;
  logic run_busy, start_busy, join_busy, yield_busy;
  logic [31:0] result_out, iter_out;
  int checks = 0, failures = 0;

  cond_loop #(.LIMIT(LIMIT), .THRESH(TH)) dut (
    .clk(clk), .reset(reset),
    .run_req(run_req), .run_busy(run_busy),
    .start_req(start_req), .start_busy(start_busy),
    .join_req(join_req), .join_busy(join_busy),
    .yield_req(yield_req), .yield_busy(yield_busy),
    .result_out(result_out), .iter_out(iter_out)
  );

  always #5 clk = ~clk;

  typedef struct {bit r; bit s; int ja; int ya; int exp_start; int exp_yield;} vec_t;
  vec_t vecs[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference: walk the loop arithmetically; cycles = INIT + 2 per visited index + final COND/DONE
  task automatic model(output int s, output int it, output int cyc);
    s = 0;
    cyc = 1;
    for (it = 0; it < LIMIT; it++) begin
      cyc += 2;
      if (it % 2 == 1) s += it;
`ifdef COND_LOOP_BREAK_EN
      if (s >= TH) begin
        cyc += 1;
        return;
      end
`endif
    end
    cyc += 2;
  endtask

  task automatic do_run(input string tag, input bit r, input bit s, input int ja, input int ya,
                        input int exp_start, input int exp_yield);
    int busy = 0, st = 0, yc = 0, bfall = -1, jfall = -1, es, ei, ec;
    bit pb = 0, pj = 0;
    model(es, ei, ec);
    @(negedge clk);
    run_req = r;
    start_req = s;
    for (int c = 1; c <= ec + 8; c++) begin
      @(negedge clk);
      run_req = 0;
      start_req = 0;
      busy += int'(run_busy);
      st += int'(start_busy);
      yc += int'(yield_busy);
      if (pb && !run_busy && bfall < 0) bfall = c;
      if (pj && !join_busy && jfall < 0) jfall = c;
      pb = run_busy;
      pj = join_busy;
      join_req = (c == ja);
      yield_req = (c == ya);
    end
    chk({tag, ".busy_cycles"}, busy, ec);
    chk({tag, ".start_pulses"}, st, exp_start);
    chk({tag, ".yield_pulses"}, yc, exp_yield);
    chk({tag, ".result"}, result_out, es);
    chk({tag, ".iter"}, iter_out, ei);
    if (ja > 0) chk({tag, ".join_fall_delay"}, jfall - bfall, 1);
  endtask

  initial begin
    int es, ei, ec, nb, ni, ns;
    bit pb;
    model(es, ei, ec);
    vecs[0] = '{1, 0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 0, 1, 0};
    vecs[2] = '{1, 1, 0, 0, 1, 0};
    vecs[3] = '{1, 0, 0, 5, 0, 1};
    vecs[4] = '{1, 0, 3, 0, 0, 0};
    vecs[5] = '{0, 1, 2, 7, 1, 1};

    repeat (2) @(negedge clk);
    chk("reset.run_busy", run_busy, 0);
    chk("reset.start_busy", start_busy, 0);
    chk("reset.join_busy", join_busy, 0);
    chk("reset.yield_busy", yield_busy, 0);
    chk("reset.result", result_out, 0);
    chk("reset.iter", iter_out, 0);
    reset = 0;

    foreach (vecs[k])
      do_run($sformatf("vec%0d", k), vecs[k].r, vecs[k].s, vecs[k].ja, vecs[k].ya,
             vecs[k].exp_start, vecs[k].exp_yield);

    // join while idle: single pulse
    @(negedge clk);
    join_req = 1;
    @(negedge clk);
    join_req = 0;
    chk("idle_join.high", join_busy, 1);
    @(negedge clk);
    chk("idle_join.low", join_busy, 0);

    // start_req held: back-to-back runs with one idle cycle between
    @(negedge clk);
    start_req = 1;
    nb = 0; ni = 0; ns = 0;
    for (int c = 1; c <= 2 * ec + 1; c++) begin
      @(negedge clk);
      nb += int'(run_busy);
      ni += int'(!run_busy);
      ns += int'(start_busy);
    end
    start_req = 0;
    chk("held_start.busy", nb, 2 * ec);
    chk("held_start.idle", ni, 1);
    chk("held_start.pulses", ns, 2);
    for (int c = 0; c < ec + 4 && run_busy; c++) @(negedge clk);
    chk("held_start.drained", run_busy, 0);
    chk("held_start.result", result_out, es);

    // reset mid-run aborts with everything cleared
    @(negedge clk);
    run_req = 1;
    @(negedge clk);
    run_req = 0;
    repeat (4) @(negedge clk);
    reset = 1;
    #1;
    chk("midreset.run_busy", run_busy, 0);
    chk("midreset.result", result_out, 0);
    chk("midreset.iter", iter_out, 0);
    chk("midreset.start_busy", start_busy, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("midreset.idle_after", run_busy, 0);
    do_run("after_reset", 1, 0, 0, 0, 0, 0);

    // randomized handshakes
    for (int n = 0; n < 16; n++) begin
      int k, ja, ya;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      k = $urandom_range(0, 2);
      ja = $urandom_range(0, 1) != 0 ? $urandom_range(1, ec) : 0;
      ya = $urandom_range(0, 1) != 0 ? $urandom_range(1, ec) : 0;
      do_run($sformatf("rnd%0d", n), k != 1, k != 0, ja, ya, k != 0 ? 1 : 0, ya > 0 ? 1 : 0);
    end
    pb = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
